acquisition_sequencer: RTL and testbench

ACQUISITION_SEQUENCER -- requirements
Module: acquisition_sequencer

---
 rtl/acquisition_sequencer.sv | 136 +++++++++++++
 tb/tb_acquisition_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acquisition_sequencer.sv
// Acquisition sequencer: arms on start, runs n_periods of (count_max+1) samples on a trig rise.
// Define ACQ_CONTINUOUS_EN to add the continuous re-arm input.
module acquisition_sequencer #(
    parameter int COUNT_WIDTH = 13,
    parameter int N_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   sclr,
    input  logic                   start,
    input  logic                   trig,
`ifdef ACQ_CONTINUOUS_EN
    input  logic                   continuous,
`endif
    input  logic [COUNT_WIDTH-1:0] count_max,
    input  logic [N_WIDTH-1:0]     n_periods,
    output logic                   addr_sclr,
    output logic [COUNT_WIDTH-1:0] addr_count_max,
    output logic                   wen,
    output logic                   busy,
    output logic                   done,
    output logic [N_WIDTH-1:0]     period_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   trig_q;
    logic [COUNT_WIDTH-1:0] cmax_q, cmax_d;
    logic [COUNT_WIDTH-1:0] scount_q, scount_d;
    logic [N_WIDTH-1:0]     nlast_q, nlast_d;
    logic [N_WIDTH-1:0]     pidx_q, pidx_d;
    logic                   done_q, done_d;

    logic trig_rise;
    logic arm;
    logic period_end;
    logic last_sample;
    logic cont;

`ifdef ACQ_CONTINUOUS_EN
    assign cont = continuous;
`else
    assign cont = 1'b0;
`endif

    assign trig_rise   = trig & ~trig_q;
    assign arm         = (state_q == S_IDLE) && start;
    assign period_end  = (scount_q == cmax_q);
    assign last_sample = period_end && (pidx_q == nlast_q);

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (trig_rise) state_d = S_RUN;
            end
            S_RUN: begin
                if (last_sample) state_d = cont ? S_ARMED : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_sclr = (state_q != S_RUN);
        wen       = (state_q == S_RUN);
        busy      = (state_q != S_IDLE);
    end

    assign addr_count_max = cmax_q;
    assign done           = done_q;
    assign period_idx     = pidx_q;

    // Shadow counters sit at zero outside RUN so RUN always starts at sample 0, period 0.
    always_comb begin
        cmax_d   = cmax_q;
        nlast_d  = nlast_q;
        done_d   = done_q;
        scount_d = '0;
        pidx_d   = '0;
        if (arm) begin
            cmax_d  = count_max;
            nlast_d = (n_periods == '0) ? '0 : n_periods - N_WIDTH'(1);
            done_d  = 1'b0;
        end
        if (state_q == S_RUN) begin
            if (period_end) begin
                scount_d = '0;
                if (last_sample) begin
                    pidx_d = '0;
                    done_d = 1'b1;
                end else begin
                    pidx_d = pidx_q + N_WIDTH'(1);
                end
            end else begin
                scount_d = scount_q + COUNT_WIDTH'(1);
                pidx_d   = pidx_q;
            end
        end
    end

    // trig_q resets high so a trig held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (sclr) begin
            trig_q   <= 1'b1;
            cmax_q   <= '0;
            nlast_q  <= '0;
            scount_q <= '0;
            pidx_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            trig_q   <= trig;
            cmax_q   <= cmax_d;
            nlast_q  <= nlast_d;
            scount_q <= scount_d;
            pidx_q   <= pidx_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Bench for acquisition_sequencer: sample-count model plus directed scenarios.
// Continuous scenario is built only with ACQ_CONTINUOUS_EN defined.
module tb_acquisition_sequencer;

    localparam int CW = 13;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          sclr;
    logic          start;
    logic          trig;
    logic [CW-1:0] count_max;
    logic [NW-1:0] n_periods;
    logic          addr_sclr;
    logic [CW-1:0] addr_count_max;
    logic          wen;
    logic          busy;
    logic          done;
    logic [NW-1:0] period_idx;
`ifdef ACQ_CONTINUOUS_EN
    logic          continuous = 1'b0;
`endif

    acquisition_sequencer #(.COUNT_WIDTH(CW), .N_WIDTH(NW)) dut (
        .clk(clk),
        .sclr(sclr),
        .start(start),
        .trig(trig),
`ifdef ACQ_CONTINUOUS_EN
        .continuous(continuous),
`endif
        .count_max(count_max),
        .n_periods(n_periods),
        .addr_sclr(addr_sclr),
        .addr_count_max(addr_count_max),
        .wen(wen),
        .busy(busy),
        .done(done),
        .period_idx(period_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: an acquisition is just a run of total=(cmax+1)*max(np,1) samples indexed by k.
    bit  seen_rst = 0;
    bit  m_armed = 0, m_run = 0, m_done = 0, m_ptrig = 1, m_cont = 0;
    int  m_cmax = 0, m_total = 0, m_k = 0;
    int  gen = 0;
    logic          p_asclr = 1'b1;
    logic [CW-1:0] p_acm = '0;
    int  wen_cnt = 0;
    int  pq[$];
    int  aq[$];

    always @(posedge clk) begin
`ifdef ACQ_CONTINUOUS_EN
        m_cont = continuous;
`else
        m_cont = 0;
`endif
        if (sclr) begin
            m_armed = 0; m_run = 0; m_done = 0;
            m_cmax = 0; m_k = 0; m_ptrig = 1;
            seen_rst = 1;
        end else begin
            if (m_run) begin
                if (m_k == m_total - 1) begin
                    m_run = 0; m_done = 1; m_k = 0; m_armed = m_cont;
                end else begin
                    m_k++;
                end
            end else if (m_armed) begin
                if (trig && !m_ptrig) begin
                    m_armed = 0; m_run = 1; m_k = 0;
                end
            end else if (start) begin
                m_armed = 1;
                m_cmax = int'(count_max);
                m_total = (m_cmax + 1) * ((n_periods == 0) ? 1 : int'(n_periods));
                m_done = 0;
            end
            m_ptrig = trig;
        end
        // Reference address generator driven by the DUT's control outputs.
        if (p_asclr) gen = 0;
        else if (gen == int'(p_acm)) gen = 0;
        else gen++;
        #1;
        if (seen_rst) begin
            check("wen", {31'd0, wen}, {31'd0, m_run});
            check("busy", {31'd0, busy}, {31'd0, m_armed | m_run});
            check("addr_sclr", {31'd0, addr_sclr}, {31'd0, !m_run});
            check("addr_count_max", {19'd0, addr_count_max}, m_cmax);
            check("done", {31'd0, done}, {31'd0, m_done});
            if (m_run) begin
                check("period_idx", {16'd0, period_idx}, m_k / (m_cmax + 1));
                check("address", gen * 4, (m_k % (m_cmax + 1)) * 4);
            end
        end
        p_asclr = addr_sclr;
        p_acm = addr_count_max;
        if (wen === 1'b1) begin
            wen_cnt++;
            pq.push_back(int'(period_idx));
            aq.push_back(gen * 4);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm(input int cm, input int np);
        count_max = CW'(cm);
        n_periods = NW'(np);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("arm_busy", {31'd0, busy}, 1);
        check("arm_done_clr", {31'd0, done}, 0);
    endtask

    task automatic fire();
        trig = 1'b0;
        tick();
        trig = 1'b1;
        check("fire_pre_wen", {31'd0, wen}, 0);
        tick();
        check("fire_latency", {31'd0, wen}, 1);
    endtask

    task automatic wait_idle(input string nm, input int max);
        for (int i = 0; i < max; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        check(nm, {31'd0, busy}, 0);
    endtask

    int exp_p[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int exp_a[8] = '{0, 4, 8, 12, 0, 4, 8, 12};

    initial begin
        sclr = 1'b1; start = 1'b0; trig = 1'b1;
        count_max = '0; n_periods = '0;
        tick(3);
        check("rst_addr_sclr", {31'd0, addr_sclr}, 1);
        check("rst_wen", {31'd0, wen}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_acm", {19'd0, addr_count_max}, 0);
        sclr = 1'b0;
        tick();

        // count_max=3, n_periods=2: two periods of four samples
        trig = 1'b0;
        arm(3, 2);
        wen_cnt = 0; pq.delete(); aq.delete();
        fire();
        wait_idle("s1_idle", 100);
        check("s1_wen_cnt", wen_cnt, 8);
        check("s1_nq", pq.size(), 8);
        for (int i = 0; i < 8 && i < pq.size(); i++) begin
            check($sformatf("s1_pidx%0d", i), pq[i], exp_p[i]);
            check($sformatf("s1_addr%0d", i), aq[i], exp_a[i]);
        end
        check("s1_done", {31'd0, done}, 1);
        tick(3);
        check("s1_done_sticky", {31'd0, done}, 1);

        // n_periods=0, count_max=0: single sample
        wen_cnt = 0;
        arm(0, 0);
        fire();
        wait_idle("s2_idle", 20);
        check("s2_wen_cnt", wen_cnt, 1);
        check("s2_done", {31'd0, done}, 1);

        // trig high before arming must not fire until it falls and rises
        trig = 1'b1;
        tick(2);
        wen_cnt = 0;
        arm(1, 1);
        tick(5);
        check("s3_no_run", wen_cnt, 0);
        check("s3_busy", {31'd0, busy}, 1);
        fire();
        wait_idle("s3_idle", 20);
        check("s3_wen_cnt", wen_cnt, 2);

        // start and trig rising together only arm
        trig = 1'b0;
        tick();
        wen_cnt = 0;
        count_max = CW'(2); n_periods = NW'(1);
        start = 1'b1; trig = 1'b1;
        tick();
        start = 1'b0;
        tick(4);
        check("s4_no_run", wen_cnt, 0);
        check("s4_busy", {31'd0, busy}, 1);
        fire();
        wait_idle("s4_idle", 20);
        check("s4_wen_cnt", wen_cnt, 3);

        // sclr on the third RUN cycle aborts without done
        wen_cnt = 0;
        arm(7, 1);
        fire();
        tick(2);
        sclr = 1'b1;
        tick();
        check("s5_wen", {31'd0, wen}, 0);
        check("s5_addr_sclr", {31'd0, addr_sclr}, 1);
        check("s5_done", {31'd0, done}, 0);
        check("s5_busy", {31'd0, busy}, 0);
        check("s5_wen_cnt", wen_cnt, 3);
        sclr = 1'b0;
        tick();

        // input changes and start pulses during RUN are ignored
        wen_cnt = 0; pq.delete();
        arm(3, 2);
        fire();
        count_max = CW'(9); n_periods = NW'(5);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        check("s6_acm", {19'd0, addr_count_max}, 3);
        wait_idle("s6_idle", 100);
        check("s6_wen_cnt", wen_cnt, 8);
        check("s6_last_pidx", (pq.size() > 0) ? pq[pq.size()-1] : -1, 1);
        check("s6_done", {31'd0, done}, 1);

`ifdef ACQ_CONTINUOUS_EN
        // continuous: three bursts of two, staying busy
        continuous = 1'b1;
        wen_cnt = 0;
        arm(1, 1);
        for (int b = 0; b < 3; b++) begin
            fire();
            tick(3);
            check($sformatf("c_busy%0d", b), {31'd0, busy}, 1);
            check($sformatf("c_done%0d", b), {31'd0, done}, 1);
        end
        check("c_wen_cnt", wen_cnt, 6);
        continuous = 1'b0;
        fire();
        wait_idle("c_idle", 20);
        check("c_wen_cnt_end", wen_cnt, 8);
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
